keys_event_ctrl: RTL and testbench
==================================

Name: keys_event_ctrl

Overview:
- Avalon-MM master that owns the push-button PIO slave (3 keys, edge-capture PIO).
- After reset, programs the PIO interrupt mask. On each PIO irq, reads the edge-capture register, clears it, and queues a key-event word into a small FIFO.
- The traffic-light FSM consumes events through a valid/ready port, so no CPU ISR is needed for keys.

Parameters:
- NUM_KEYS, 3, number of key bits used from the PIO registers.
- FIFO_DEPTH, 4, event FIFO entries; must be a power of two and at least 2.
- IRQ_MASK_INIT, 3'b111, value written to the PIO mask register after reset.
- TS_WIDTH, 16, timestamp width; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- enable  in  1  when 0, the controller does not start new PIO reads.
- avm_address  out  2  PIO register address.
- avm_chipselect  out  1  PIO select.
- avm_write_n  out  1  active-low write strobe.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  PIO read data, registered inside the PIO, 1-cycle latency.
- key_irq  in  1  PIO interrupt output.
- evt_valid  out  1  event available at FIFO head.
- evt_ready  in  1  consumer accepts the event.
- evt_keys  out  NUM_KEYS  key mask of the head event; never zero while evt_valid=1.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
- busy  out  1  high in every state except WAIT.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=CFG; all avm_* outputs idle: chipselect=0, write_n=1, address=0, writedata=0.
  - FIFO emptied; evt_valid=0, evt_keys=0, overflow=0.
  - Reset mid-transaction abandons the transaction; no partial push.
- Bus rule: chipselect is 1 only in CFG, RD_ADDR and CLR; all other states drive the idle values above.
- FSM states:
  - CFG: address=2, chipselect=1, write_n=0, writedata=IRQ_MASK_INIT zero-extended. Next state WAIT. Occurs once per reset.
  - WAIT: if key_irq=1 and enable=1, go to RD_ADDR; otherwise stay.
  - RD_ADDR: address=3, chipselect=1, write_n=1. Next state RD_DATA.
  - RD_DATA: hold address=3, chipselect=0. Capture cap = avm_readdata[NUM_KEYS-1:0] & IRQ_MASK_INIT. Next state CLR.
  - CLR: address=3, chipselect=1, write_n=0, writedata=all ones. The write clears all edge bits. Next state PUSH.
  - PUSH: if cap != 0, push cap into the FIFO. If the FIFO is full, drop cap and set overflow=1. Next state WAIT.
- Latency: key_irq=1 sampled in WAIT at edge N gives RD_ADDR at N+1, RD_DATA at N+2, CLR at N+3, PUSH at N+4, evt_valid=1 from N+5.
- key_irq is low again by the time WAIT is re-entered, so no spurious re-read. A spurious read (cap=0) pushes nothing.
- Edges captured by the PIO between the RD_ADDR sample and the CLR write are lost by the slave's clear-all semantics. This is accepted behaviour and is not flagged.
- FIFO:
  - First-word-fall-through; evt_keys is valid in the same cycle as evt_valid.
  - Pop when evt_valid && evt_ready.
  - Push and pop in the same cycle while full: push succeeds with no overflow.
  - Push into an empty FIFO: evt_valid rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.
- overflow clears only on reset.
- enable=0 while busy: the current sequence completes; only the WAIT->RD_ADDR transition is gated.

Optional Feature:
- Macro KEYS_EVENT_CTRL_TIMESTAMP_EN.
- Defined:
  - Adds a free-running TS_WIDTH counter, reset to 0, wrapping at 2^TS_WIDTH.
  - Counter value is sampled in RD_DATA and stored with each event.
  - Adds output port evt_ts (out, TS_WIDTH), aligned with evt_keys.
- Undefined: no counter, no evt_ts port; FIFO word width is NUM_KEYS.

Decomposition:
- Package keys_event_ctrl_pkg:
  - FSM state enum {CFG, WAIT, RD_ADDR, RD_DATA, CLR, PUSH}.
  - PIO register address constants: ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3.
- Sub-module keys_evt_fifo: parameterised width/depth FWFT FIFO with full, empty, push and pop.

Test Plan:
- Reset, then release: cycle 1 shows a write of 0x7 to address 2. Then idle bus, busy=0, evt_valid=0, overflow=0.
- Key0 edge with evt_ready=1: read at address 3, then write of 0xFFFFFFFF to address 3. evt_valid=1 with evt_keys=3'b001 exactly 5 cycles after key_irq is sampled; popped the next cycle.
- Key0 and key2 edges in the same cycle: exactly one event, evt_keys=3'b101.
- evt_ready=0 with five separate key presses: FIFO holds 4 events in order, overflow=1. Then evt_ready=1 drains 4 events; overflow stays 1.
- reset_n=0 in RD_DATA with 2 events queued: FIFO empty, bus idle, no push. CFG mask write repeats after release.
- enable=0 with key_irq=1 held: no bus activity for 20 cycles. enable=1: read sequence starts the next cycle.

Source files
------------

// File: rtl/keys_event_ctrl_pkg.sv
// Shared FSM encodings, PIO register map and bus command helper for keys_event_ctrl.
package keys_event_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t CFG     = 3'd0;
  localparam state_t WAIT    = 3'd1;
  localparam state_t RD_ADDR = 3'd2;
  localparam state_t RD_DATA = 3'd3;
  localparam state_t CLR     = 3'd4;
  localparam state_t PUSH    = 3'd5;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef struct packed {
    logic        sel;
    logic        write_n;
    logic [1:0]  address;
    logic [31:0] writedata;
  } avm_cmd_t;

  localparam avm_cmd_t AVM_IDLE = '{sel: 1'b0, write_n: 1'b1, address: ADDR_DATA, writedata: 32'd0};

  // Bus drive for each state; only CFG, RD_ADDR and CLR assert the select.
  function automatic avm_cmd_t bus_cmd(input state_t st, input logic [31:0] mask_word);
    avm_cmd_t c;
    c = AVM_IDLE;
    case (st)
      CFG: begin
        c.sel       = 1'b1;
        c.write_n   = 1'b0;
        c.address   = ADDR_MASK;
        c.writedata = mask_word;
      end
      RD_ADDR: begin
        c.sel     = 1'b1;
        c.address = ADDR_EDGE;
      end
      RD_DATA: c.address = ADDR_EDGE;
      CLR: begin
        c.sel       = 1'b1;
        c.write_n   = 1'b0;
        c.address   = ADDR_EDGE;
        c.writedata = 32'hFFFF_FFFF;
      end
      default: c = AVM_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/keys_evt_fifo.sv
// First-word-fall-through FIFO: head visible while !empty; zero-latency pop, push lands next cycle.
// Push while full is accepted only when a pop happens in the same cycle.
module keys_evt_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/keys_event_ctrl.sv
// Avalon-MM master for the key PIO: masks irq at reset, reads+clears edge capture, queues events (evt_valid 5 cycles after irq sample).
// evt_ready low fills the FIFO, further events are dropped with sticky overflow; KEYS_EVENT_CTRL_TIMESTAMP_EN adds evt_ts.
module keys_event_ctrl
  import keys_event_ctrl_pkg::*;
#(
  parameter int                  NUM_KEYS      = 3,
  parameter int                  FIFO_DEPTH    = 4,
`ifdef KEYS_EVENT_CTRL_TIMESTAMP_EN
  parameter int                  TS_WIDTH      = 16,
`endif
  parameter logic [NUM_KEYS-1:0] IRQ_MASK_INIT = 3'b111
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic [1:0]          avm_address,
  output logic                avm_chipselect,
  output logic                avm_write_n,
  output logic [31:0]         avm_writedata,
  input  logic [31:0]         avm_readdata,
  input  logic                key_irq,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [NUM_KEYS-1:0] evt_keys,
`ifdef KEYS_EVENT_CTRL_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0] evt_ts,
`endif
  output logic                overflow,
  output logic                busy
);

  localparam logic [31:0] MASK_WORD = 32'(IRQ_MASK_INIT);

`ifdef KEYS_EVENT_CTRL_TIMESTAMP_EN
  localparam int FIFO_W = NUM_KEYS + TS_WIDTH;
`else
  localparam int FIFO_W = NUM_KEYS;
`endif

  state_t              state;
  state_t              state_nxt;
  avm_cmd_t            cmd;
  logic [NUM_KEYS-1:0] cap;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FIFO_W-1:0]   push_data;
  logic [FIFO_W-1:0]   head;
  logic                readdata_unused;

  assign readdata_unused = ^avm_readdata[31:NUM_KEYS];

  always_comb begin
    state_nxt = state;
    case (state)
      CFG:     state_nxt = WAIT;
      WAIT:    if (key_irq && enable) state_nxt = RD_ADDR;
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: state_nxt = CLR;
      CLR:     state_nxt = PUSH;
      PUSH:    state_nxt = WAIT;
      default: state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CFG;
    end else begin
      state <= state_nxt;
    end
  end

  // Bus is held idle while reset is asserted so the CFG write only appears once reset is released.
  always_comb begin
    cmd = bus_cmd(state, MASK_WORD);
    if (!reset_n) begin
      cmd = AVM_IDLE;
    end
  end

  assign avm_chipselect = cmd.sel;
  assign avm_write_n    = cmd.write_n;
  assign avm_address    = cmd.address;
  assign avm_writedata  = cmd.writedata;
  assign busy           = (state != WAIT);

  // PIO returns read data one cycle after the RD_ADDR select, i.e. during RD_DATA.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap <= '0;
    end else if (state == RD_DATA) begin
      cap <= avm_readdata[NUM_KEYS-1:0] & IRQ_MASK_INIT;
    end
  end

`ifdef KEYS_EVENT_CTRL_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts;
  logic [TS_WIDTH-1:0] ts_cap;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts     <= '0;
      ts_cap <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (state == RD_DATA) begin
        ts_cap <= ts;
      end
    end
  end

  assign push_data = {ts_cap, cap};
  assign evt_ts    = evt_valid ? head[FIFO_W-1:NUM_KEYS] : '0;
`else
  assign push_data = cap;
`endif

  assign push      = (state == PUSH) && (cap != '0);
  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready;
  assign evt_keys  = evt_valid ? head[NUM_KEYS-1:0] : '0;

  keys_evt_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A simultaneous pop frees the slot, so only a push into a full, non-draining FIFO is lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keys_event_ctrl.sv
// Directed bench for keys_event_ctrl with a behavioural edge-capture PIO slave.
module tb_keys_event_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        key_irq;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  evt_keys;
  logic        overflow;
  logic        busy;
`ifdef KEYS_EVENT_CTRL_TIMESTAMP_EN
  logic [15:0] evt_ts;
`endif

  logic [2:0]  press;
  logic [2:0]  edge_cap;
  logic [2:0]  mask_reg;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  keys_event_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .key_irq        (key_irq),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_keys       (evt_keys),
`ifdef KEYS_EVENT_CTRL_TIMESTAMP_EN
    .evt_ts         (evt_ts),
`endif
    .overflow       (overflow),
    .busy           (busy)
  );

  // PIO slave: registered read data, write to edge register clears all bits.
  always @(posedge clk) begin
    if (!reset_n) begin
      edge_cap     <= 3'b0;
      mask_reg     <= 3'b0;
      avm_readdata <= 32'h0;
    end else begin
      if (avm_chipselect && !avm_write_n && avm_address == 2'd2) mask_reg <= avm_writedata[2:0];
      if (avm_chipselect && !avm_write_n && avm_address == 2'd3) edge_cap <= 3'b0;
      else edge_cap <= edge_cap | press;
      if (avm_chipselect && avm_write_n && avm_address == 2'd3) avm_readdata <= {29'h0AAA_AAAA, edge_cap};
      else avm_readdata <= 32'hFFFF_FFFF;
    end
  end

  assign key_irq = |(edge_cap & mask_reg);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_press(input logic [2:0] k);
    press = k;
    @(negedge clk);
    press = 3'b0;
  endtask

  logic [2:0] seq [5];

  initial begin
    seq = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110};
    reset_n = 1'b0; enable = 1'b1; evt_ready = 1'b0; press = 3'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_wn", avm_write_n, 1);
    chk("rst_addr", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_keys", evt_keys, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 1);

    // Release: first cycle is the mask write.
    reset_n = 1'b1; #1;
    chk("cfg_cs", avm_chipselect, 1);
    chk("cfg_wn", avm_write_n, 0);
    chk("cfg_addr", avm_address, 2);
    chk("cfg_wdata", avm_writedata, 32'h7);
    @(negedge clk);
    chk("idle_cs", avm_chipselect, 0);
    chk("idle_wn", avm_write_n, 1);
    chk("idle_addr", avm_address, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", evt_valid, 0);
    chk("idle_ovf", overflow, 0);

    // Single key0 edge, full sequence cycle by cycle.
    evt_ready = 1'b1;
    do_press(3'b001);
    @(negedge clk);
    chk("rd_cs", avm_chipselect, 1);
    chk("rd_wn", avm_write_n, 1);
    chk("rd_addr", avm_address, 3);
    chk("rd_busy", busy, 1);
    @(negedge clk);
    chk("rdd_cs", avm_chipselect, 0);
    chk("rdd_wn", avm_write_n, 1);
    @(negedge clk);
    chk("clr_cs", avm_chipselect, 1);
    chk("clr_wn", avm_write_n, 0);
    chk("clr_addr", avm_address, 3);
    chk("clr_wdata", avm_writedata, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("push_cs", avm_chipselect, 0);
    chk("push_valid", evt_valid, 0);
    @(negedge clk);
    chk("k0_valid", evt_valid, 1);
    chk("k0_keys", evt_keys, 3'b001);
    @(negedge clk);
    chk("k0_popped", evt_valid, 0);
    chk("k0_busy", busy, 0);

    // Key0 and key2 together: one event.
    do_press(3'b101);
    repeat (4) @(negedge clk);
    chk("two_early", evt_valid, 0);
    @(negedge clk);
    chk("two_valid", evt_valid, 1);
    chk("two_keys", evt_keys, 3'b101);
    repeat (3) @(negedge clk);
    chk("two_single", evt_valid, 0);

    // Five presses with consumer stalled: four kept in order, fifth dropped.
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_press(seq[i]);
      repeat (6) @(negedge clk);
      if (i == 3) chk("ovf_before", overflow, 0);
    end
    chk("ovf_set", overflow, 1);
    chk("fill_valid", evt_valid, 1);
    evt_ready = 1'b1; #1;
    chk("drain_0", evt_keys, seq[0]);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("drain_n", evt_keys, seq[i]);
    end
    @(negedge clk);
    chk("drain_empty", evt_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Reset in RD_DATA with two events queued.
    evt_ready = 1'b0;
    do_press(3'b001);
    repeat (6) @(negedge clk);
    do_press(3'b010);
    repeat (6) @(negedge clk);
    chk("q2_valid", evt_valid, 1);
    do_press(3'b100);
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_cs", avm_chipselect, 0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", evt_valid, 0);
    chk("rstmid_keys", evt_keys, 0);
    chk("rstmid_cs", avm_chipselect, 0);
    chk("rstmid_ovf", overflow, 0);
    @(negedge clk);
    reset_n = 1'b1; #1;
    chk("recfg_cs", avm_chipselect, 1);
    chk("recfg_wn", avm_write_n, 0);
    chk("recfg_addr", avm_address, 2);
    chk("recfg_wdata", avm_writedata, 32'h7);
    repeat (6) @(negedge clk);
    chk("nopush_valid", evt_valid, 0);
    chk("nopush_busy", busy, 0);

    // enable gating with irq held high, then enable dropped mid-sequence.
    evt_ready = 1'b1;
    enable = 1'b0;
    do_press(3'b001);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("en_gate_cs", avm_chipselect, 0);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("en_rd_cs", avm_chipselect, 1);
    chk("en_rd_addr", avm_address, 3);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("en_keep_valid", evt_valid, 1);
    chk("en_keep_keys", evt_keys, 3'b001);
    @(negedge clk);
    chk("en_done_busy", busy, 0);
    chk("en_done_valid", evt_valid, 0);
    chk("final_ovf", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
